// File: rtl/reloj_hhmm_bcd.sv
// Purpose : 24-hour HH:MM:SS timekeeper feeding BCD hour/minute digits to the display mux.
// Latency : all outputs registered; a second boundary appears one cycle after the prescaler's last count.
// Backpres: none; free-running core, Run gates time, IncMin/IncHor act every cycle they are high.
//
// Ports:
//   clk, rst        : clock (rising edge) and asynchronous active-high reset
//   Run             : 1 = prescaler and seconds advance, 0 = they hold
//   IncMin, IncHor  : manual increment pulses (each high cycle is one step)
//   DecHor, UniHor  : hour tens / units (BCD, 00..23)
//   DecMin, UniMin  : minute tens / units (BCD, 00..59)
//   Seg             : seconds, binary 0..59
//   SecTick         : one-cycle pulse coincident with each natural Seg update
//   Colon           : 1 during the first half of each second, 0 during the second half

module reloj_hhmm_bcd #(
  parameter int DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Run,
  input  logic       IncMin,
  input  logic       IncHor,
  output logic [3:0] DecHor,
  output logic [3:0] UniHor,
  output logic [3:0] DecMin,
  output logic [3:0] UniMin,
  output logic [5:0] Seg,
  output logic       SecTick,
  output logic       Colon
);

  localparam int            PW       = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(DIV / 2);

  logic [PW-1:0] preCnt;
  logic [PW-1:0] preNxt;
  logic [5:0]    segNxt;
  logic [3:0]    decMinNxt;
  logic [3:0]    uniMinNxt;
  logic [3:0]    decHorNxt;
  logic [3:0]    uniHorNxt;

  logic manualEvt;
  logic preWrap;
  logic secEvt;
  logic segAt59;
  logic minAt59;
  logic horAt23;
  logic minStep;
  logic horStep;

  // Event chain. A manual increment swallows a coincident natural second so
  // the two never stack; that is why secEvt is masked by manualEvt.
  always_comb begin
    manualEvt = IncMin | IncHor;
    preWrap   = Run && (preCnt == PRE_LAST);
    secEvt    = preWrap && !manualEvt;
    segAt59   = (Seg >= 6'd59);
    minAt59   = (DecMin >= 4'd5) && (UniMin >= 4'd9);
    horAt23   = (DecHor >= 4'd2) && (UniHor >= 4'd3);
    // IncMin wraps 59 -> 00 on its own and never carries into the hours;
    // only the natural seconds chain produces an hour carry.
    minStep   = IncMin | (secEvt & segAt59);
    horStep   = IncHor | (secEvt & segAt59 & minAt59);
  end

  // Prescaler: cleared by any manual action, frozen while Run is low.
  always_comb begin
    preNxt = preCnt;
    if (manualEvt) begin
      preNxt = '0;
    end else if (Run) begin
      if (preWrap) begin
        preNxt = '0;
      end else begin
        preNxt = preCnt + 1'b1;
      end
    end
  end

  // Seconds counter.
  always_comb begin
    segNxt = Seg;
    if (manualEvt) begin
      segNxt = 6'd0;
    end else if (secEvt) begin
      segNxt = segAt59 ? 6'd0 : (Seg + 6'd1);
    end
  end

  // Minute BCD pair. The >= compares make any out-of-range digit fall back
  // into range on the next step instead of running away.
  always_comb begin
    decMinNxt = DecMin;
    uniMinNxt = UniMin;
    if (minStep) begin
      if (UniMin >= 4'd9) begin
        uniMinNxt = 4'd0;
        decMinNxt = (DecMin >= 4'd5) ? 4'd0 : (DecMin + 4'd1);
      end else begin
        uniMinNxt = UniMin + 4'd1;
      end
    end
  end

  // Hour BCD pair: 23 -> 00 is checked before the units 9 -> 0 rule.
  always_comb begin
    decHorNxt = DecHor;
    uniHorNxt = UniHor;
    if (horStep) begin
      if (horAt23) begin
        decHorNxt = 4'd0;
        uniHorNxt = 4'd0;
      end else if (UniHor >= 4'd9) begin
        uniHorNxt = 4'd0;
        decHorNxt = DecHor + 4'd1;
      end else begin
        uniHorNxt = UniHor + 4'd1;
      end
    end
  end

  // Colon follows the prescaler value that is being loaded, so it lines up
  // with preCnt in the same cycle: high at reset (prescaler 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preCnt  <= '0;
      Seg     <= 6'd0;
      DecMin  <= 4'd0;
      UniMin  <= 4'd0;
      DecHor  <= 4'd0;
      UniHor  <= 4'd0;
      SecTick <= 1'b0;
      Colon   <= 1'b1;
    end else begin
      preCnt  <= preNxt;
      Seg     <= segNxt;
      DecMin  <= decMinNxt;
      UniMin  <= uniMinNxt;
      DecHor  <= decHorNxt;
      UniHor  <= uniHorNxt;
      SecTick <= secEvt;
      Colon   <= (preNxt < PRE_HALF);
    end
  end

`ifndef SYNTHESIS
  // Digit ranges are an invariant of the counter chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (DecHor <= 4'd2) else $error("DecHor out of range: %0d", DecHor);
      assert (UniHor <= 4'd9) else $error("UniHor out of range: %0d", UniHor);
      assert (!(DecHor == 4'd2 && UniHor > 4'd3)) else $error("hour above 23");
      assert (DecMin <= 4'd5) else $error("DecMin out of range: %0d", DecMin);
      assert (UniMin <= 4'd9) else $error("UniMin out of range: %0d", UniMin);
      assert (Seg <= 6'd59) else $error("Seg out of range: %0d", Seg);
    end
  end
`endif

endmodule

// File: tb/tb_reloj_hhmm_bcd.sv
// Bench for reloj_hhmm_bcd with a 4-cycle second.
// Reference keeps time as seconds-of-day plus a prescaler count and derives
// the expected digits with division/modulo.

module tb_reloj_hhmm_bcd;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       Run;
  logic       IncMin;
  logic       IncHor;
  logic [3:0] DecHor;
  logic [3:0] UniHor;
  logic [3:0] DecMin;
  logic [3:0] UniMin;
  logic [5:0] Seg;
  logic       SecTick;
  logic       Colon;

  logic [23:0] dutVec;
  assign dutVec = {DecHor, UniHor, DecMin, UniMin, Seg, SecTick, Colon};

  int tests = 0;
  int fails = 0;

  // Reference state.
  int tod = 0;     // seconds since midnight
  int pre = 0;     // prescaler count
  bit expTick = 1'b0;

  always #5 clk = ~clk;

  reloj_hhmm_bcd #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .Run(Run), .IncMin(IncMin), .IncHor(IncHor),
    .DecHor(DecHor), .UniHor(UniHor), .DecMin(DecMin), .UniMin(UniMin),
    .Seg(Seg), .SecTick(SecTick), .Colon(Colon)
  );

  function automatic logic [23:0] expVec();
    int h;
    int m;
    int s;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 6'(s), expTick, (pre < DIV / 2)};
  endfunction

  function automatic logic [23:0] mkVec(int h, int m, int s, bit tick, bit colon);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 6'(s), tick, colon};
  endfunction

  task automatic modelReset();
    tod = 0;
    pre = 0;
    expTick = 1'b0;
  endtask

  task automatic modelStep(input bit run, input bit im, input bit ih);
    int h;
    int m;
    h = tod / 3600;
    m = (tod / 60) % 60;
    expTick = 1'b0;
    if (im || ih) begin
      if (im) m = (m + 1) % 60;
      if (ih) h = (h + 1) % 24;
      tod = h * 3600 + m * 60;
      pre = 0;
    end else if (run) begin
      if (pre == DIV - 1) begin
        pre = 0;
        tod = (tod + 1) % 86400;
        expTick = 1'b1;
      end else begin
        pre = pre + 1;
      end
    end
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic drive(input bit run, input bit im, input bit ih);
    Run = run;
    IncMin = im;
    IncHor = ih;
    @(posedge clk);
    modelStep(run, im, ih);
    #1;
  endtask

  task automatic applyReset();
    Run = 1'b0;
    IncMin = 1'b0;
    IncHor = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    modelReset();
    #1;
  endtask

  // Reach hh:mm:ss with prescaler 0 using Inc pulses then natural seconds.
  task automatic preset(input int h, input int m, input int s);
    applyReset();
    for (int i = 0; i < h; i++) drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < m; i++) drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < s * DIV; i++) drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [23:0] want;
    applyReset();
    want = mkVec(0, 0, 0, 1'b0, 1'b1);
    tests++;
    if (dutVec !== want) begin
      fails++;
      $display("FAIL reset_state got %h want %h", dutVec, want);
    end
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (dutVec !== expVec()) begin
      fails++;
      $display("FAIL reset_idle got %h want %h", dutVec, expVec());
    end
  endtask

  task automatic test_run_minute();
    int ticks;
    int bad;
    logic [23:0] want;
    applyReset();
    ticks = 0;
    bad = 0;
    for (int c = 0; c < 60 * DIV; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (SecTick === 1'b1) ticks++;
      tests++;
      if (dutVec !== expVec()) begin
        fails++;
        bad++;
        if (bad < 5) $display("FAIL run_cycle%0d got %h want %h", c, dutVec, expVec());
      end
    end
    tests++;
    if (ticks != 60) begin
      fails++;
      $display("FAIL run_tick_count got %0d want 60", ticks);
    end
    want = mkVec(0, 1, 0, 1'b1, 1'b1);
    tests++;
    if (dutVec !== want) begin
      fails++;
      $display("FAIL run_minute_carry got %h want %h", dutVec, want);
    end
  endtask

  task automatic test_hour_carry();
    logic [23:0] want;
    preset(9, 59, 59);
    for (int c = 0; c < DIV; c++) drive(1'b1, 1'b0, 1'b0);
    want = mkVec(10, 0, 0, 1'b1, 1'b1);
    tests++;
    if (dutVec !== want || dutVec !== expVec()) begin
      fails++;
      $display("FAIL hour_carry_0959 got %h want %h", dutVec, want);
    end
  endtask

  task automatic test_day_wrap();
    logic [23:0] want;
    preset(23, 59, 59);
    for (int c = 0; c < DIV - 1; c++) drive(1'b1, 1'b0, 1'b0);
    want = mkVec(23, 59, 59, 1'b0, 1'b0);
    tests++;
    if (dutVec !== want) begin
      fails++;
      $display("FAIL day_wrap_before got %h want %h", dutVec, want);
    end
    drive(1'b1, 1'b0, 1'b0);
    want = mkVec(0, 0, 0, 1'b1, 1'b1);
    tests++;
    if (dutVec !== want || dutVec !== expVec()) begin
      fails++;
      $display("FAIL day_wrap_after got %h want %h", dutVec, want);
    end
  endtask

  task automatic test_hold();
    int tickSeen;
    logic [23:0] want;
    preset(3, 14, 7);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    tickSeen = 0;
    for (int c = 0; c < 50; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (SecTick !== 1'b0) tickSeen++;
      tests++;
      if (dutVec !== expVec()) begin
        fails++;
        $display("FAIL hold_cycle%0d got %h want %h", c, dutVec, expVec());
      end
    end
    tests++;
    if (tickSeen != 0) begin
      fails++;
      $display("FAIL hold_sectick got %0d ticks want 0", tickSeen);
    end
    want = mkVec(3, 14, 7, 1'b0, 1'b0);
    tests++;
    if (dutVec !== want) begin
      fails++;
      $display("FAIL hold_frozen got %h want %h", dutVec, want);
    end
    // Prescaler must resume from 2: two more cycles finish the second.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    want = mkVec(3, 14, 8, 1'b1, 1'b1);
    tests++;
    if (dutVec !== want) begin
      fails++;
      $display("FAIL hold_resume got %h want %h", dutVec, want);
    end
  endtask

  task automatic test_manual_wrap();
    logic [23:0] want;
    preset(12, 59, 0);
    for (int c = 0; c < 10; c++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    want = mkVec(12, 0, 0, 1'b0, 1'b1);
    tests++;
    if (dutVec !== want || dutVec !== expVec()) begin
      fails++;
      $display("FAIL minute_wrap_1259 got %h want %h", dutVec, want);
    end
    for (int i = 0; i < 11; i++) drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    want = mkVec(0, 7, 0, 1'b0, 1'b1);
    tests++;
    if (dutVec !== want || dutVec !== expVec()) begin
      fails++;
      $display("FAIL hour_wrap_2307 got %h want %h", dutVec, want);
    end
  endtask

  task automatic test_contention();
    logic [23:0] want;
    preset(5, 9, 59);
    for (int c = 0; c < DIV - 1; c++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    want = mkVec(5, 10, 0, 1'b0, 1'b1);
    tests++;
    if (dutVec !== want || dutVec !== expVec()) begin
      fails++;
      $display("FAIL incmin_on_wrap got %h want %h", dutVec, want);
    end
    preset(23, 59, 0);
    drive(1'b1, 1'b1, 1'b1);
    want = mkVec(0, 0, 0, 1'b0, 1'b1);
    tests++;
    if (dutVec !== want || dutVec !== expVec()) begin
      fails++;
      $display("FAIL both_inc_2359 got %h want %h", dutVec, want);
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] want;
    preset(7, 30, 20);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    want = mkVec(0, 0, 0, 1'b0, 1'b1);
    tests++;
    if (dutVec !== want) begin
      fails++;
      $display("FAIL async_reset got %h want %h", dutVec, want);
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    bit r;
    bit im;
    bit ih;
    preset(23, 58, 50);
    bad = 0;
    for (int c = 0; c < 800; c++) begin
      r  = ($urandom % 8) != 0;
      im = ($urandom % 20) == 0;
      ih = ($urandom % 30) == 0;
      drive(r, im, ih);
      tests++;
      if (dutVec !== expVec()) begin
        fails++;
        bad++;
        if (bad < 5) $display("FAIL random_cycle%0d got %h want %h", c, dutVec, expVec());
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    Run = 1'b0;
    IncMin = 1'b0;
    IncHor = 1'b0;
    #1;
    test_reset();
    test_run_minute();
    test_hour_carry();
    test_day_wrap();
    test_hold();
    test_manual_wrap();
    test_contention();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
